// File: rtl/ca_grid_gen.sv
// ROWS x COLS outer-totalistic cellular automaton with Generations-style decay.
// Every cell computes its successor in parallel from the registered grid.
// A write to a cell overrides the advance for that cell only.

// Successor of one cell, given the live/dead state of its 8 Moore neighbours.
module ca_cell_next #(
  parameter int NUM_STATES = 2,
  parameter int STATE_BITS = 2
) (
  input  logic [STATE_BITS-1:0] state,
  input  logic [8:0]            nb,
  input  logic [8:0]            birth_mask,
  input  logic [8:0]            survive_mask,
  output logic [STATE_BITS-1:0] next
);
  localparam logic [STATE_BITS-1:0] ONE = STATE_BITS'(1);
  localparam logic [STATE_BITS-1:0] TWO = STATE_BITS'(2);

  logic [3:0] cnt;

  // Count the live neighbours, then apply birth/survive/decay.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < 9; k++) cnt = cnt + 4'(nb[k]);
    next = '0;
    if (state == '0)
      next = birth_mask[cnt] ? ONE : '0;
    else if (state == ONE)
      next = survive_mask[cnt] ? ONE : ((NUM_STATES > 2) ? TWO : '0);
    else if (32'(state) + 1 < NUM_STATES)
      next = state + ONE;
  end
endmodule

module ca_grid_gen #(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int NUM_STATES = 2,
  parameter int STATE_BITS = 2,
  parameter int GEN_BITS   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             run,
  input  logic                             step,
  input  logic                             wrap,
  input  logic [8:0]                       birth_mask,
  input  logic [8:0]                       survive_mask,
  input  logic                             wr_en,
  input  logic [$clog2(ROWS)-1:0]          wr_row,
  input  logic [$clog2(COLS)-1:0]          wr_col,
  input  logic [STATE_BITS-1:0]            wr_state,
  input  logic [$clog2(ROWS)-1:0]          rd_row,
  input  logic [$clog2(COLS)-1:0]          rd_col,
  output logic [STATE_BITS-1:0]            rd_state,
  output logic [ROWS*COLS-1:0]             alive_map,
  output logic [GEN_BITS-1:0]              generation,
  output logic [$clog2(ROWS*COLS+1)-1:0]   population,
  output logic                             stable
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(N + 1);

  logic [N-1:0][STATE_BITS-1:0] cells, nxt;
  logic [N-1:0]                 alive, wr_sel, rd_sel;
  logic [STATE_BITS-1:0]        wr_val;
  logic                         adv, wr_hit;

  assign adv    = run | step;
  assign wr_hit = |wr_sel;                       // out-of-range address selects nothing
  assign wr_val = (32'(wr_state) < NUM_STATES) ? wr_state : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int I = r * COLS + c;
      logic [8:0] nb;

      assign alive[I]  = (cells[I] == STATE_BITS'(1));
      assign wr_sel[I] = wr_en && (wr_row == RW'(r)) && (wr_col == CW'(c));
      assign rd_sel[I] = (rd_row == RW'(r)) && (rd_col == CW'(c));

      // Neighbour taps resolved at elaboration: in-grid taps are direct,
      // off-grid taps use the toroidal partner gated by wrap.
      for (genvar k = 0; k < 9; k++) begin : g_nb
        localparam int RR = r + k / 3 - 1;
        localparam int CC = c + k % 3 - 1;
        localparam int WR = (RR + ROWS) % ROWS;
        localparam int WC = (CC + COLS) % COLS;
        if (k == 4) begin : g_self
          assign nb[k] = 1'b0;
        end else if (RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS) begin : g_in
          assign nb[k] = alive[RR * COLS + CC];
        end else begin : g_edge
          assign nb[k] = wrap & alive[WR * COLS + WC];
        end
      end

      ca_cell_next #(.NUM_STATES(NUM_STATES), .STATE_BITS(STATE_BITS)) u_cell (
        .state(cells[I]), .nb(nb), .birth_mask(birth_mask),
        .survive_mask(survive_mask), .next(nxt[I])
      );
    end
  end

  // Cell registers: write wins over advance for the addressed cell.
  always_ff @(posedge clk) begin
    if (reset) cells <= '0;
    else
      for (int i = 0; i < N; i++)
        if (wr_sel[i])  cells[i] <= wr_val;
        else if (adv)   cells[i] <= nxt[i];
  end

  // Generation counter and stability flag; any landed write breaks stability.
  always_ff @(posedge clk) begin
    if (reset) begin
      generation <= '0;
      stable     <= 1'b0;
    end else begin
      if (adv) generation <= generation + 1'b1;
      if (wr_hit)   stable <= 1'b0;
      else if (adv) stable <= (nxt == cells);
    end
  end

  // Read mux; an out-of-range address matches no cell and yields 0.
  always_comb begin
    rd_state = '0;
    for (int i = 0; i < N; i++) if (rd_sel[i]) rd_state = cells[i];
  end

  // Live-cell count straight off the registers.
  always_comb begin
    population = '0;
    for (int i = 0; i < N; i++) population = population + PW'(alive[i]);
  end

  assign alive_map = alive;
endmodule
